// File: rtl/mc_axi_pkg.sv
// Shared types, constants and the beat address generator for the AXI3 write front end.
package mc_axi_pkg;

  localparam int MC_ADDR_W = 32;
  localparam int MC_ID_W   = 4;
  localparam int MC_LEN_W  = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} wr_state_t;

  typedef struct packed {
    logic [MC_ID_W-1:0]   id;
    logic [MC_ADDR_W-1:0] addr;
    logic [MC_LEN_W-1:0]  len;
    logic [2:0]           size;
    burst_t               burst;
  } aw_entry_t;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [MC_LEN_W-1:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // Address of the beat after 'addr'. Callers pass INCR for illegal WRAP/RSVD bursts.
  function automatic logic [MC_ADDR_W-1:0] next_beat_addr(
    input logic [MC_ADDR_W-1:0] addr,
    input logic [MC_LEN_W-1:0]  len,
    input logic [2:0]           size,
    input burst_t               burst
  );
    logic [MC_ADDR_W-1:0] step;
    logic [MC_ADDR_W-1:0] win;
    logic [MC_ADDR_W-1:0] lin;
    step = MC_ADDR_W'(1) << size;
    win  = (MC_ADDR_W'(len) + MC_ADDR_W'(1)) << size;
    lin  = addr + step;
    case (burst)
      BURST_FIXED: return addr;
      // Keep the window base bits, let the offset inside the window roll over.
      BURST_WRAP:  return (addr & ~(win - MC_ADDR_W'(1))) | (lin & (win - MC_ADDR_W'(1)));
      default:     return lin;
    endcase
  endfunction

endpackage

// File: rtl/mc_axi3_wr_frontend_if.sv
// AXI3 AW/W/B channels plus the per-beat memory request channel.
interface mc_axi3_wr_frontend_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_LEN   = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ADDR_LEN-1:0]     awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_data;
  logic [DATA_WIDTH/8-1:0] mem_strb;
  logic                    mem_last;

  // Front end side: receives AW/W, drives B and memory requests.
  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wid, wdata, wstrb, wlast, bready, mem_ready,
    output awready, wready, bvalid, bid, bresp,
    output mem_valid, mem_addr, mem_data, mem_strb, mem_last
  );

  // Interconnect / scheduler side.
  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wid, wdata, wstrb, wlast, bready, mem_ready,
    input  awready, wready, bvalid, bid, bresp,
    input  mem_valid, mem_addr, mem_data, mem_strb, mem_last
  );
endinterface

// File: rtl/mc_axi_aw_fifo.sv
// Small synchronous FIFO holding accepted AW requests.
module mc_axi_aw_fifo
  import mc_axi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  aw_entry_t push_data,
  input  logic      pop,
  output aw_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);

  aw_entry_t        mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage needs no reset: only slots behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mc_axi3_wr_frontend.sv
// AXI3 write front end: queues AW, serialises each burst into per-beat memory writes, one B per burst.
module mc_axi3_wr_frontend
  import mc_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = MC_ADDR_W,
  parameter int ID_WIDTH   = MC_ID_W,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_LEN   = MC_LEN_W,
  parameter int AW_DEPTH   = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mc_axi3_wr_frontend_if.slave  bus
);

  wr_state_t             state_q, state_d;
  aw_entry_t             cur_q;
  aw_entry_t             push_entry;
  aw_entry_t             fifo_head;
  aw_entry_t             pop_entry;
  logic [ADDR_LEN-1:0]   cnt_q;
  logic                  err_q;
  logic                  fifo_full, fifo_empty;
  logic                  pop, head_bad, beat_fire, last_beat;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ID_WIDTH-1:0]   burst_id;
  logic [DATA_WIDTH-1:0] beat_data;

  assign push_entry.id    = bus.awid;
  assign push_entry.addr  = bus.awaddr;
  assign push_entry.len   = bus.awlen;
  assign push_entry.size  = bus.awsize;
  assign push_entry.burst = burst_t'(bus.awburst);

  assign bus.awready = !fifo_full;

  mc_axi_aw_fifo #(.DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.awvalid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign beat_fire = (state_q == DATA) && bus.wvalid && bus.mem_ready;
  assign last_beat = (cnt_q == cur_q.len);
  assign head_bad  = (fifo_head.burst == BURST_RSVD) ||
                     ((fifo_head.burst == BURST_WRAP) && !wrap_len_ok(fifo_head.len));

  // Illegal WRAP lengths and the reserved encoding degrade to INCR.
  always_comb begin
    pop_entry = fifo_head;
    if (head_bad) pop_entry.burst = BURST_INCR;
  end

  assign beat_addr    = cur_q.addr;
  assign burst_id     = cur_q.id;
  assign beat_data    = bus.wdata;
  assign bus.mem_addr = beat_addr;
  assign bus.mem_data = beat_data;
  assign bus.mem_strb = bus.wstrb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: exactly len+1 beats per burst regardless of wlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty)            state_d = DATA;
      DATA:    if (beat_fire && last_beat) state_d = RESP;
      RESP:    if (bus.bready)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Outputs: W passes straight through to the scheduler, B held in RESP.
  always_comb begin
    bus.wready    = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_last  = 1'b0;
    bus.bvalid    = 1'b0;
    bus.bid       = '0;
    bus.bresp     = RESP_OKAY;
    case (state_q)
      DATA: begin
        bus.wready    = bus.mem_ready;
        bus.mem_valid = bus.wvalid;
        bus.mem_last  = last_beat;
      end
      RESP: begin
        bus.bvalid = 1'b1;
        bus.bid    = burst_id;
        bus.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Burst context: load on pop, advance address/count and accumulate errors per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (pop) begin
      cur_q <= pop_entry;
      cnt_q <= '0;
      err_q <= head_bad;
    end else if (beat_fire) begin
      err_q      <= err_q | (bus.wid != cur_q.id) | (bus.wlast != last_beat);
      cnt_q      <= cnt_q + 1'b1;
      cur_q.addr <= next_beat_addr(cur_q.addr, cur_q.len, cur_q.size, cur_q.burst);
    end
  end

endmodule
